// File: rtl/spinn_pkg.sv
// Shared definitions for the SpiNNaker packet path.
// Contents:
//   SPINN_PKT_W       packet width in bits
//   SPINN_TIMEOUT_DEF default stalled-cycle count before the link is declared down
//   SPINN_MAX_CH      widest request vector rr_pick handles
//   rr_pick()         round-robin search helper
package spinn_pkg;

  localparam int unsigned SPINN_PKT_W       = 72;
  localparam int unsigned SPINN_TIMEOUT_DEF = 128;
  localparam int unsigned SPINN_MAX_CH      = 8;

  // Returns the first set bit of req searching upward from last+1, wrapping mod 8.
  // Callers zero the unused upper request bits, which makes a mod-8 search
  // equivalent to a mod-NUM_CH search. With no request set it returns last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = last;
    // Walk from farthest to nearest so the nearest candidate is the one kept.
    for (int i = 8; i >= 1; i--) begin
      idx = last + 3'(i);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i          per-channel requests
//   en_i           arbitration allowed this cycle
//   gnt_o          one-hot grant (all zero when nothing is granted)
//   gnt_idx_o      index of the granted channel
//   gnt_vld_o      a grant is issued this cycle
// The pointer resets to NUM_CH-1, so channel 0 is served first.
import spinn_pkg::*;

module rr_arbiter #(
  parameter int unsigned NUM_CH = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      en_i,
  output logic [NUM_CH-1:0]         gnt_o,
  output logic [$clog2(NUM_CH)-1:0] gnt_idx_o,
  output logic                      gnt_vld_o
);

  localparam int unsigned IdxW = $clog2(NUM_CH);

  logic [IdxW-1:0]         last_q, last_d;
  logic [SPINN_MAX_CH-1:0] req_pad;
  logic [2:0]              last_pad;
  logic [2:0]              pick;

  always_comb begin
    req_pad               = '0;
    req_pad[NUM_CH-1:0]   = req_i;
    last_pad              = 3'(last_q);
    pick                  = rr_pick(req_pad, last_pad);
    gnt_idx_o             = IdxW'(pick);
    gnt_vld_o             = en_i & (|req_i);
    gnt_o                 = '0;
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
    last_d                = gnt_vld_o ? gnt_idx_o : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= IdxW'(NUM_CH - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/spinn_pkt_arbiter.sv
// Shares one SpiNNaker packet link between NUM_CH packet sources.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_vld/in_rdy per-channel packet inputs (channel c at bits [72c+71:72c])
//   out_data/out_ch/out_vld/out_rdy  registered single-entry output buffer
//   ch_en                 channel enable mask; disabled channels are drained and counted
//   cnt_clr               synchronous clear of all drop counters
//   link_down             set after TIMEOUT consecutive stalled cycles, cleared by out_rdy
//   drop_cnt              per-channel saturating drop counters (CNT_W bits each)
import spinn_pkg::*;

module spinn_pkt_arbiter #(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned TIMEOUT = SPINN_TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [72*NUM_CH-1:0]      in_data,
  input  logic [NUM_CH-1:0]         in_vld,
  output logic [NUM_CH-1:0]         in_rdy,
  output logic [71:0]               out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_vld,
  input  logic                      out_rdy,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic                      cnt_clr,
  output logic                      link_down,
  output logic [CNT_W*NUM_CH-1:0]   drop_cnt
);

  localparam int unsigned ChW    = $clog2(NUM_CH);
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [SPINN_PKT_W-1:0] out_data_q, out_data_d;
  logic [ChW-1:0]         out_ch_q, out_ch_d;
  logic                   out_vld_q, out_vld_d;
  logic                   link_down_q, link_down_d;
  logic [StallW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]       drop_q [NUM_CH];
  logic [CNT_W-1:0]       drop_d [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [ChW-1:0]    gnt_idx;
  logic              gnt_vld;
  logic              arb_en;
  logic              stall;
  logic [NUM_CH-1:0] drop_inc;

  assign elig   = in_vld & ch_en;
  assign arb_en = (~out_vld_q | out_rdy) & ~link_down_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (elig),
    .en_i      (arb_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  // Disabled channels and a downed link sink everything so sources never stall.
  assign in_rdy   = gnt | ~ch_en | {NUM_CH{link_down_q}};
  assign drop_inc = in_vld & (~ch_en | {NUM_CH{link_down_q}});

  assign stall = out_vld_q & ~out_rdy;

  // Stall counter and link state.
  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + StallW'(1) : '0;
    link_down_d = link_down_q;
    if (link_down_q) begin
      if (out_rdy) link_down_d = 1'b0;
    end else if (stall && (stall_cnt_q == StallW'(TIMEOUT - 1))) begin
      link_down_d = 1'b1;
      stall_cnt_d = '0;
    end
  end

  // Output buffer: load on grant, otherwise empty on unload or when the link goes down.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    if (gnt_vld) begin
      out_vld_d  = 1'b1;
      out_data_d = in_data[int'(gnt_idx) * SPINN_PKT_W +: SPINN_PKT_W];
      out_ch_d   = gnt_idx;
    end else if (out_rdy || link_down_d) begin
      out_vld_d  = 1'b0;
    end
  end

  // Drop counters: clear wins over increment, increments saturate.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      drop_d[c] = drop_q[c];
      if (cnt_clr)                             drop_d[c] = '0;
      else if (drop_inc[c] && drop_q[c] != '1) drop_d[c] = drop_q[c] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_vld_q   <= 1'b0;
      link_down_q <= 1'b0;
      stall_cnt_q <= '0;
      for (int c = 0; c < NUM_CH; c++) drop_q[c] <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_vld_q   <= out_vld_d;
      link_down_q <= link_down_d;
      stall_cnt_q <= stall_cnt_d;
      for (int c = 0; c < NUM_CH; c++) drop_q[c] <= drop_d[c];
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_vld   = out_vld_q;
  assign link_down = link_down_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_drop_out
    assign drop_cnt[c*CNT_W +: CNT_W] = drop_q[c];
  end

endmodule

// File: tb/tb_spinn_pkt_arbiter.sv
module tb_spinn_pkt_arbiter;

  localparam int unsigned NumCh   = 3;
  localparam int unsigned Timeout = 128;
  localparam int unsigned CntW    = 16;

  logic              clk;
  logic              rst_n;
  logic [72*NumCh-1:0] in_data;
  logic [NumCh-1:0]  in_vld;
  logic [NumCh-1:0]  in_rdy;
  logic [71:0]       out_data;
  logic [1:0]        out_ch;
  logic              out_vld;
  logic              out_rdy;
  logic [NumCh-1:0]  ch_en;
  logic              cnt_clr;
  logic              link_down;
  logic [CntW*NumCh-1:0] drop_cnt;

  logic [71:0] dat [NumCh];
  logic [71:0] dref [NumCh];

  int n_checks;
  int n_fail;

  assign in_data = {dat[2], dat[1], dat[0]};

  spinn_pkt_arbiter #(
    .NUM_CH  (NumCh),
    .TIMEOUT (Timeout),
    .CNT_W   (CntW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .ch_en     (ch_en),
    .cnt_clr   (cnt_clr),
    .link_down (link_down),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CntW-1:0] drop_of(input int c);
    return drop_cnt[c*CntW +: CntW];
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    dref[0]  = 72'h11_2233_4455_6677_8800;
    dref[1]  = 72'h22_AABB_CCDD_EEFF_0011;
    dref[2]  = 72'h33_0102_0304_0506_0722;
    for (int c = 0; c < NumCh; c++) dat[c] = dref[c];
    rst_n   = 1'b0;
    in_vld  = '0;
    out_rdy = 1'b1;
    ch_en   = 3'b111;
    cnt_clr = 1'b0;
    tick();
    tick();

    // Reset state.
    check_eq("rst_out_vld", 72'(out_vld), 72'd0);
    check_eq("rst_out_data", out_data, 72'd0);
    check_eq("rst_out_ch", 72'(out_ch), 72'd0);
    check_eq("rst_link_down", 72'(link_down), 72'd0);
    check_eq("rst_drop_cnt", 72'(drop_cnt), 72'd0);
    rst_n = 1'b1;
    tick();

    // Fairness: all valid, link always ready.
    in_vld = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("rr_in_rdy_%0d", i), 72'(in_rdy), 72'(3'b001 << (i % 3)));
      tick();
      check_eq($sformatf("rr_out_ch_%0d", i), 72'(out_ch), 72'(i % 3));
      check_eq($sformatf("rr_out_vld_%0d", i), 72'(out_vld), 72'd1);
      check_eq($sformatf("rr_out_data_%0d", i), out_data, dref[i % 3]);
    end

    // Backpressure with 0xA5 buffered from channel 0.
    in_vld = '0;
    tick();
    check_eq("bp_drain_vld", 72'(out_vld), 72'd0);
    dat[0]  = 72'hA5;
    in_vld  = 3'b001;
    out_rdy = 1'b0;
    #1;
    check_eq("bp_load_rdy", 72'(in_rdy), 72'(3'b001));
    tick();
    check_eq("bp_load_data", out_data, 72'hA5);
    dat[0] = dref[0];
    in_vld = 3'b111;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq($sformatf("bp_in_rdy_%0d", i), 72'(in_rdy), 72'd0);
      tick();
      check_eq($sformatf("bp_hold_%0d", i), out_data, 72'hA5);
    end
    check_eq("bp_vld_held", 72'(out_vld), 72'd1);
    check_eq("bp_link_up", 72'(link_down), 72'd0);
    out_rdy = 1'b1;
    #1;
    check_eq("bp_release_rdy", 72'(in_rdy), 72'(3'b010));
    tick();
    check_eq("bp_next_ch", 72'(out_ch), 72'd1);
    check_eq("bp_next_data", out_data, dref[1]);
    in_vld = '0;
    tick();
    check_eq("bp_empty", 72'(out_vld), 72'd0);

    // Disable channel 1: it is drained and counted, 0 and 2 alternate.
    ch_en  = 3'b101;
    in_vld = 3'b111;
    #1;
    check_eq("dis_rdy1", 72'(in_rdy[1]), 72'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("dis_out_ch_%0d", i), 72'(out_ch), (i % 2 == 0) ? 72'd2 : 72'd0);
    end
    check_eq("dis_drop1", 72'(drop_of(1)), 72'd5);
    check_eq("dis_drop0", 72'(drop_of(0)), 72'd0);
    in_vld = '0;
    ch_en  = 3'b111;
    tick();

    // Timeout: channel 0 buffered, link stalled for Timeout edges.
    in_vld  = 3'b001;
    out_rdy = 1'b0;
    tick();
    in_vld = '0;
    check_eq("to_vld_rise", 72'(out_vld), 72'd1);
    repeat (Timeout - 1) tick();
    check_eq("to_not_yet", 72'(link_down), 72'd0);
    check_eq("to_vld_before", 72'(out_vld), 72'd1);
    tick();
    check_eq("to_link_down", 72'(link_down), 72'd1);
    check_eq("to_vld_flush", 72'(out_vld), 72'd0);
    in_vld = 3'b001;
    #1;
    check_eq("to_all_rdy", 72'(in_rdy), 72'(3'b111));
    repeat (4) tick();
    check_eq("to_still_down", 72'(link_down), 72'd1);
    check_eq("to_drop0", 72'(drop_of(0)), 72'd4);
    check_eq("to_drop1", 72'(drop_of(1)), 72'd5);
    in_vld  = '0;
    out_rdy = 1'b1;
    tick();
    check_eq("to_link_up", 72'(link_down), 72'd0);
    in_vld = 3'b111;
    #1;
    check_eq("to_resume_rdy", 72'(in_rdy), 72'(3'b010));
    tick();
    check_eq("to_resume_ch", 72'(out_ch), 72'd1);
    in_vld = '0;
    tick();

    // Counters: clear, saturate, clear beats a same-cycle drop.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_eq("cnt_cleared", 72'(drop_cnt), 72'd0);
    ch_en  = 3'b000;
    in_vld = 3'b111;
    repeat (65535) tick();
    check_eq("cnt_full", 72'(drop_of(2)), 72'hFFFF);
    repeat (3) tick();
    check_eq("cnt_sat", 72'(drop_of(0)), 72'hFFFF);
    check_eq("cnt_no_out", 72'(out_vld), 72'd0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check_eq("cnt_clr_wins", 72'(drop_of(0)), 72'd0);
    in_vld = '0;
    tick();

    // Asynchronous reset mid-stream.
    ch_en  = 3'b011;
    in_vld = 3'b111;
    tick();
    check_eq("mid_ch0", 72'(out_ch), 72'd0);
    tick();
    check_eq("mid_ch1", 72'(out_ch), 72'd1);
    check_eq("mid_drop2", 72'(drop_of(2)), 72'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_vld", 72'(out_vld), 72'd0);
    check_eq("arst_drop", 72'(drop_cnt), 72'd0);
    check_eq("arst_link", 72'(link_down), 72'd0);
    tick();
    rst_n = 1'b1;
    ch_en = 3'b111;
    tick();
    check_eq("arst_first_ch", 72'(out_ch), 72'd0);
    check_eq("arst_first_vld", 72'(out_vld), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
